// File: rtl/fifo_pkg.sv
// Shared types and helpers for the streaming FIFO.
//   level_width(depth) : width needed to hold a level of 0..depth+1
//   out_mode_e         : read-side mode, mirrors the REG_OUT parameter
package fifo_pkg;

  typedef enum logic [0:0] {
    OUT_FWFT = 1'b0,
    OUT_REG  = 1'b1
  } out_mode_e;

  // Level can reach DEPTH+1 when the output register is populated.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for fifo_stream: one synchronous write port, one combinational
// read port, no reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address (0..DEPTH-1)
//   wdata_i : write data
//   raddr_i : read address (0..DEPTH-1)
//   rdata_o : read data, combinational from raddr_i
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_stream.sv
// Single-clock streaming FIFO with valid/ready on both sides, arbitrary depth,
// almost-full/almost-empty flags, synchronous flush and an optional registered
// output stage.
//   clk_i            : clock
//   rst_ni           : asynchronous active-low reset
//   flush_i          : synchronous clear, wins over push/pop
//   s_valid_i/s_ready_o/s_data_i : write stream
//   m_valid_o/m_ready_i/m_data_o : read stream
//   level_o          : words held (includes output register when REG_OUT=1)
//   almost_full_o    : level_o >= AF_THRESH
//   almost_empty_o   : level_o <= AE_THRESH
module fifo_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH),
  parameter int unsigned LEVEL_WIDTH = level_width(DEPTH),
  parameter int unsigned AF_THRESH   = DEPTH - 2,
  parameter int unsigned AE_THRESH   = 2,
  parameter int unsigned REG_OUT     = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [DATA_WIDTH-1:0]  s_data_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [DATA_WIDTH-1:0]  m_data_o,
  output logic [LEVEL_WIDTH-1:0] level_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o
);

  localparam logic [LEVEL_WIDTH-1:0] DepthCnt = LEVEL_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0]  LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam out_mode_e              OutMode  = (REG_OUT != 0) ? OUT_REG : OUT_FWFT;

  logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LEVEL_WIDTH-1:0] store_cnt_q, store_cnt_d;
  logic [DATA_WIDTH-1:0]  rdata;
  logic                   stored_any;
  logic                   push;
  logic                   pop;
  logic                   rd_en;   // a word leaves the storage array this cycle

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == LastAddr) ? '0 : p + 1'b1;
  endfunction

  // s_ready depends on registered state only: a full FIFO refuses a push even
  // when a pop happens in the same cycle.
  assign s_ready_o  = (store_cnt_q != DepthCnt);
  assign stored_any = (store_cnt_q != '0);
  assign push       = s_valid_i & s_ready_o;
  assign pop        = m_valid_o & m_ready_i;

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk_i  (clk_i),
    .we_i   (push & ~flush_i),
    .waddr_i(wr_ptr_q),
    .wdata_i(s_data_i),
    .raddr_i(rd_ptr_q),
    .rdata_o(rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    store_cnt_d = store_cnt_q;
    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      store_cnt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = next_ptr(wr_ptr_q);
      end
      if (rd_en) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      unique case ({push, rd_en})
        2'b10:   store_cnt_d = store_cnt_q + 1'b1;
        2'b01:   store_cnt_d = store_cnt_q - 1'b1;
        default: store_cnt_d = store_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      store_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  if (OutMode == OUT_REG) begin : g_reg_out
    logic                  out_v_q;
    logic [DATA_WIDTH-1:0] out_q;

    // Refill whenever the output slot is empty or being drained; no bypass,
    // so a fresh push reaches m_valid two cycles later.
    assign rd_en = (~out_v_q | pop) & stored_any;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        out_v_q <= 1'b0;
        out_q   <= '0;
      end else if (flush_i) begin
        out_v_q <= 1'b0;
      end else if (rd_en) begin
        out_v_q <= 1'b1;
        out_q   <= rdata;
      end else if (pop) begin
        out_v_q <= 1'b0;
      end
    end

    assign m_valid_o = out_v_q;
    assign m_data_o  = out_q;
    assign level_o   = store_cnt_q + LEVEL_WIDTH'(out_v_q);
  end else begin : g_fwft
    assign rd_en     = pop;
    assign m_valid_o = stored_any;
    assign m_data_o  = rdata;
    assign level_o   = store_cnt_q;
  end

  assign almost_full_o  = (32'(level_o) >= AF_THRESH);
  assign almost_empty_o = (32'(level_o) <= AE_THRESH);

endmodule

// File: tb/tb_fifo_stream.sv
module tb_fifo_stream;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned LW    = $clog2(DEPTH + 2);

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          fl;
    int unsigned   lvl;
    logic          srdy;
    logic          mval;
    logic          af;
    logic          ae;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          f_s_valid = 1'b0, f_m_ready = 1'b0, f_flush = 1'b0;
  logic [DW-1:0] f_s_data = '0;
  logic          f_s_ready, f_m_valid, f_af, f_ae;
  logic [DW-1:0] f_m_data;
  logic [LW-1:0] f_level;

  logic          r_s_valid = 1'b0, r_m_ready = 1'b0, r_flush = 1'b0;
  logic [DW-1:0] r_s_data = '0;
  logic          r_s_ready, r_m_valid, r_af, r_ae;
  logic [DW-1:0] r_m_data;
  logic [LW-1:0] r_level;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] sb[$];
  vec_t          vecs[$];

  always #5 clk = ~clk;

  fifo_stream #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(3), .AE_THRESH(1), .REG_OUT(0)
  ) u_fwft (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f_flush),
    .s_valid_i(f_s_valid), .s_ready_o(f_s_ready), .s_data_i(f_s_data),
    .m_valid_o(f_m_valid), .m_ready_i(f_m_ready), .m_data_o(f_m_data),
    .level_o(f_level), .almost_full_o(f_af), .almost_empty_o(f_ae)
  );

  fifo_stream #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(3), .AE_THRESH(1), .REG_OUT(1)
  ) u_reg (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(r_flush),
    .s_valid_i(r_s_valid), .s_ready_o(r_s_ready), .s_data_i(r_s_data),
    .m_valid_o(r_m_valid), .m_ready_i(r_m_ready), .m_data_o(r_m_data),
    .level_o(r_level), .almost_full_o(r_af), .almost_empty_o(r_ae)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic sv, input logic [DW-1:0] sd, input logic mr,
                              input logic fl, input int unsigned lvl, input logic srdy,
                              input logic mval, input logic af, input logic ae);
    vec_t v;
    v.sv = sv; v.sd = sd; v.mr = mr; v.fl = fl; v.lvl = lvl;
    v.srdy = srdy; v.mval = mval; v.af = af; v.ae = ae;
    return v;
  endfunction

  initial begin
    bit exp_push, exp_pop;

    // Expected state after each edge: lvl, s_ready, m_valid, almost_full, almost_empty.
    // Fill, 6th push refused
    vecs.push_back(mk(1, 8'h10, 0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(1, 8'h11, 0, 0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 8'h12, 0, 0, 3, 1, 1, 1, 0));
    vecs.push_back(mk(1, 8'h13, 0, 0, 4, 1, 1, 1, 0));
    vecs.push_back(mk(1, 8'h14, 0, 0, 5, 0, 1, 1, 0));
    vecs.push_back(mk(1, 8'h15, 0, 0, 5, 0, 1, 1, 0));
    // Drain
    vecs.push_back(mk(0, 8'h00, 1, 0, 4, 1, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 3, 1, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 1));
    // Wrap with one-word lag
    vecs.push_back(mk(1, 8'hA0, 0, 0, 1, 1, 1, 0, 1));
    for (int k = 1; k < 7; k++) begin
      vecs.push_back(mk(1, 8'(8'hA0 + k), 1, 0, 1, 1, 1, 0, 1));
    end
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 1));
    // Concurrent push/pop at level 2
    vecs.push_back(mk(1, 8'h01, 0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(1, 8'h02, 0, 0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 8'h03, 1, 0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 1));
    // Flush with a simultaneous push, then the next push must come out
    vecs.push_back(mk(1, 8'h41, 0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(1, 8'h42, 0, 0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 8'h43, 0, 0, 3, 1, 1, 1, 0));
    vecs.push_back(mk(1, 8'h77, 0, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 8'h88, 0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 1));

    // ---- Reset, then asynchronous reset mid-operation ----
    step(); step();
    rst_n = 1'b1;
    f_s_valid = 1'b1; r_s_valid = 1'b1; f_s_data = 8'hE1; r_s_data = 8'hE1;
    step();
    f_s_data = 8'hE2; r_s_data = 8'hE2;
    step();
    f_s_valid = 1'b0; r_s_valid = 1'b0;
    step();
    chk("pre_reset_f_level", 32'(f_level), 2);
    chk("pre_reset_r_level", 32'(r_level), 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_f_s_ready", 32'(f_s_ready), 1);
    chk("rst_f_m_valid", 32'(f_m_valid), 0);
    chk("rst_f_level",   32'(f_level),   0);
    chk("rst_f_ae",      32'(f_ae),      1);
    chk("rst_f_af",      32'(f_af),      0);
    chk("rst_r_s_ready", 32'(r_s_ready), 1);
    chk("rst_r_m_valid", 32'(r_m_valid), 0);
    chk("rst_r_level",   32'(r_level),   0);
    chk("rst_r_ae",      32'(r_ae),      1);
    chk("rst_r_af",      32'(r_af),      0);
    step();
    rst_n = 1'b1;
    step();

    // ---- Table-driven FWFT run with scoreboard ----
    foreach (vecs[i]) begin
      f_s_valid = vecs[i].sv;
      f_s_data  = vecs[i].sd;
      f_m_ready = vecs[i].mr;
      f_flush   = vecs[i].fl;
      exp_push  = vecs[i].sv && !vecs[i].fl && (sb.size() < DEPTH);
      exp_pop   = vecs[i].mr && !vecs[i].fl && (sb.size() > 0);
      if (exp_pop) chk($sformatf("v%0d_pop_data", i), 32'(f_m_data), 32'(sb[0]));
      step();
      if (vecs[i].fl) begin
        sb.delete();
      end else begin
        if (exp_pop) void'(sb.pop_front());
        if (exp_push) sb.push_back(vecs[i].sd);
      end
      chk($sformatf("v%0d_level", i),   32'(f_level),   32'(vecs[i].lvl));
      chk($sformatf("v%0d_s_ready", i), 32'(f_s_ready), 32'(vecs[i].srdy));
      chk($sformatf("v%0d_m_valid", i), 32'(f_m_valid), 32'(vecs[i].mval));
      chk($sformatf("v%0d_af", i),      32'(f_af),      32'(vecs[i].af));
      chk($sformatf("v%0d_ae", i),      32'(f_ae),      32'(vecs[i].ae));
    end
    f_s_valid = 1'b0; f_m_ready = 1'b0; f_flush = 1'b0;
    chk("sb_empty", 32'(sb.size()), 0);

    // ---- REG_OUT=1: two-cycle latency and fill to DEPTH+1 ----
    r_s_valid = 1'b1; r_s_data = 8'h55; r_m_ready = 1'b0;
    step();
    r_s_valid = 1'b0;
    chk("reg_lat1_m_valid", 32'(r_m_valid), 0);
    chk("reg_lat1_level",   32'(r_level),   1);
    step();
    chk("reg_lat2_m_valid", 32'(r_m_valid), 1);
    chk("reg_lat2_m_data",  32'(r_m_data),  32'h55);
    chk("reg_lat2_level",   32'(r_level),   1);
    for (int k = 1; k < 6; k++) begin
      r_s_valid = 1'b1; r_s_data = 8'(8'h55 + k);
      step();
      chk($sformatf("reg_fill%0d_level", k), 32'(r_level), 32'(k + 1));
    end
    chk("reg_full_s_ready", 32'(r_s_ready), 0);
    r_s_data = 8'h5B;
    step();
    r_s_valid = 1'b0;
    chk("reg_refused_level", 32'(r_level), 6);
    r_m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("reg_drain%0d_m_valid", k), 32'(r_m_valid), 1);
      chk($sformatf("reg_drain%0d_m_data", k),  32'(r_m_data),  32'(8'h55 + k));
      step();
    end
    r_m_ready = 1'b0;
    chk("reg_drained_m_valid", 32'(r_m_valid), 0);
    chk("reg_drained_level",   32'(r_level),   0);

    // ---- REG_OUT=1: flush at level 3 with a simultaneous push ----
    for (int k = 0; k < 3; k++) begin
      r_s_valid = 1'b1; r_s_data = 8'(8'h31 + k);
      step();
    end
    chk("reg_preflush_level", 32'(r_level), 3);
    r_flush = 1'b1; r_s_data = 8'h77;
    step();
    r_flush = 1'b0; r_s_valid = 1'b0;
    chk("reg_flush_level",   32'(r_level),   0);
    chk("reg_flush_m_valid", 32'(r_m_valid), 0);
    chk("reg_flush_s_ready", 32'(r_s_ready), 1);
    r_s_valid = 1'b1; r_s_data = 8'h88;
    step();
    r_s_valid = 1'b0;
    step();
    chk("reg_postflush_m_valid", 32'(r_m_valid), 1);
    chk("reg_postflush_m_data",  32'(r_m_data),  32'h88);
    chk("reg_postflush_level",   32'(r_level),   1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
